serial_adder: RTL

//   Bit-serial WIDTH-bit adder built around a single full_adder cell.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_adder.sv | 25 ++
 rtl/serial_adder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the FSM state type and its
//   encodings. Only S_IDLE, S_RUN and S_DONE are legal; the FSM treats any
//   other value as a corrupted state and returns to S_IDLE.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell: {Cout, S} = A + B + Cin, built from gates.
// Ports
//   S     out  sum bit
//   Cout  out  carry-out bit
//   A     in   operand bit A
//   B     in   operand bit B
//   Cin   in   carry-in bit
// ---------------------------------------------------------------------------
module full_adder (
    output logic S,
    output logic Cout,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    logic half_sum;

    assign half_sum = A ^ B;
    assign S        = half_sum ^ Cin;
    assign Cout     = (A & B) | (Cin & half_sum);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. On an accepted start the operands and carry-in
//   are captured; one bit pair per clock (LSB first) is then fed through a
//   single full_adder cell with the carry held in a flip-flop. After WIDTH
//   RUN cycles the result is registered and done pulses for one cycle.
//
//   Handshake: start is a request sampled only in IDLE; a, b and cin are
//   captured on the same edge. busy is high in RUN and DONE and start is
//   ignored while it is high. done is high for exactly one cycle and sum/cout
//   are valid in that cycle and hold until the next done (0 after reset).
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   operation request
//   a      in   operand A (WIDTH)
//   b      in   operand B (WIDTH)
//   cin    in   carry-in
//   busy   out  operation in flight (RUN or DONE)
//   done   out  one-cycle completion pulse
//   sum    out  registered sum (WIDTH)
//   cout   out  registered carry-out
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Wide enough to hold WIDTH-1 for any WIDTH >= 1.
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    full_adder u_full_adder (
        .S    (fa_s),
        .Cout (fa_c),
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts the LSB-first stream
    // sits in natural bit order. Written this way so WIDTH == 1 needs no
    // special-case slice.
    always_comb begin
        s_shift            = s_sr >> 1;
        s_shift[WIDTH-1]   = fa_s;
    end

    // FSM next state and state-decoded outputs.
    always_comb begin
        state_next = S_IDLE;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                busy       = 1'b1;
                state_next = last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand capture, serial shifting, carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_shift;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= s_shift;
                        cout <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
